// File: rtl/bytes_to_word.sv
// Receive-side packer: four UART RX bytes, MSB first, become one 32-bit word
// presented with a valid/ack handshake; an inter-byte timeout discards partial words.
module bytes_to_word #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_done_tick,
  input  logic [7:0]  rx_data,
  input  logic        word_ack,
  output logic        word_valid,
  output logic [31:0] data_out,
  output logic        receiving,
  output logic        timeout_tick,
  output logic        overrun
);

  // A zero timeout still needs a 1-bit timer so the declarations stay legal.
  localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  state_t             state;
  logic [1:0]         byte_cnt;
  logic [TMR_W-1:0]   timer;
  logic [31:0]        shift_buf;
  logic               timeout_hit;

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end else begin : g_timeout
      assign timeout_hit = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      byte_cnt     <= 2'd0;
      timer        <= '0;
      shift_buf    <= 32'd0;
      word_valid   <= 1'b0;
      data_out     <= 32'd0;
      receiving    <= 1'b0;
      timeout_tick <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      timeout_tick <= 1'b0;
      overrun      <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_done_tick) begin
            shift_buf <= {shift_buf[23:0], rx_data};
            byte_cnt  <= 2'd1;
            timer     <= '0;
            receiving <= 1'b1;
            state     <= COLLECT;
          end
        end

        COLLECT: begin
          // A tick on the terminal timer count wins over the timeout.
          if (rx_done_tick) begin
            shift_buf <= {shift_buf[23:0], rx_data};
            timer     <= '0;
            if (byte_cnt == 2'd3) begin
              data_out   <= {shift_buf[23:0], rx_data};
              word_valid <= 1'b1;
              receiving  <= 1'b0;
              byte_cnt   <= 2'd0;
              state      <= HOLD;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end else if (timeout_hit) begin
            shift_buf    <= 32'd0;
            byte_cnt     <= 2'd0;
            timer        <= '0;
            timeout_tick <= 1'b1;
            receiving    <= 1'b0;
            state        <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        HOLD: begin
          if (word_ack) begin
            word_valid <= 1'b0;
            if (rx_done_tick) begin
              shift_buf <= {shift_buf[23:0], rx_data};
              byte_cnt  <= 2'd1;
              timer     <= '0;
              receiving <= 1'b1;
              state     <= COLLECT;
            end else begin
              state <= IDLE;
            end
          end else if (rx_done_tick) begin
            overrun <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
